// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shift unit: shift modes and FSM states.
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_LSR = 3'b000,
    MODE_ASR = 3'b001,
    MODE_LSL = 3'b010,
    MODE_ROR = 3'b011,
    MODE_ROL = 3'b100,
    MODE_SRI = 3'b101,
    MODE_SLI = 3'b110,
    MODE_RSV = 3'b111
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift step: next register value and the bit that leaves it.
module shift_step
  import shift_pkg::*;
#(
  parameter int x = 8
) (
  input  logic [x-1:0] q,
  input  logic [2:0]   mode,
  input  logic         serial_in,
  output logic [x-1:0] next_q,
  output logic         out_bit
);

  always_comb begin
    next_q  = q;
    out_bit = 1'b0;
    case (shift_mode_e'(mode))
      MODE_LSR: begin
        next_q  = {1'b0, q[x-1:1]};
        out_bit = q[0];
      end
      MODE_ASR: begin
        next_q  = {q[x-1], q[x-1:1]};
        out_bit = q[0];
      end
      MODE_LSL: begin
        next_q  = {q[x-2:0], 1'b0};
        out_bit = q[x-1];
      end
      MODE_ROR: begin
        next_q  = {q[0], q[x-1:1]};
        out_bit = q[0];
      end
      MODE_ROL: begin
        next_q  = {q[x-2:0], q[x-1]};
        out_bit = q[x-1];
      end
      MODE_SRI: begin
        next_q  = {serial_in, q[x-1:1]};
        out_bit = q[0];
      end
      MODE_SLI: begin
        next_q  = {q[x-2:0], serial_in};
        out_bit = q[x-1];
      end
      default: begin
        next_q  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Sequential load-and-shift unit: latches an operand, shifts it one bit per cycle
// for a clamped count, then pulses done for one cycle.
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter  int x  = 8,
  localparam int aw = $clog2(x) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [aw-1:0] amount,
  input  logic [x-1:0]  data_in,
  input  logic          serial_in,
  output logic [x-1:0]  q,
  output logic          shift_out,
  output logic          busy,
  output logic          done
);

  state_e          state;
  state_e          state_nxt;
  shift_mode_e     mode_r;
  logic [aw-1:0]   cnt;
  logic [aw-1:0]   amount_clamped;
  logic [x-1:0]    step_q;
  logic            step_out;

  // Shifting further than the width is pointless, so the count saturates at x.
  assign amount_clamped = (amount > aw'(x)) ? aw'(x) : amount;

  shift_step #(
    .x(x)
  ) u_step (
    .q        (q),
    .mode     (mode_r),
    .serial_in(serial_in),
    .next_q   (step_q),
    .out_bit  (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (amount_clamped != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (cnt == aw'(1)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // The reserved mode still counts down so done timing matches the other modes.
  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= '0;
      shift_out <= 1'b0;
      cnt       <= '0;
      mode_r    <= MODE_LSR;
    end else if (clr) begin
      q         <= '0;
      shift_out <= 1'b0;
      cnt       <= '0;
    end else if (state == ST_IDLE && start) begin
      q         <= data_in;
      shift_out <= 1'b0;
      mode_r    <= shift_mode_e'(mode);
      cnt       <= amount_clamped;
    end else if (state == ST_SHIFT) begin
      if (mode_r != MODE_RSV) begin
        q         <= step_q;
        shift_out <= step_out;
      end
      cnt <= cnt - aw'(1);
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: directed vectors, aborts and randomized operations.
module tb_seq_shift_unit;

  localparam int X  = 8;
  localparam int AW = $clog2(X) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          start;
  logic [2:0]    mode;
  logic [AW-1:0] amount;
  logic [X-1:0]  data_in;
  logic          serial_in;
  logic [X-1:0]  q;
  logic          shift_out;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [X-1:0] q;
    logic         so;
    int           done_cyc;
    string        name;
  } exp_t;

  exp_t         sb[$];
  logic [X-1:0] last_q;

  seq_shift_unit #(
    .x(X)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .start    (start),
    .mode     (mode),
    .amount   (amount),
    .data_in  (data_in),
    .serial_in(serial_in),
    .q        (q),
    .shift_out(shift_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Whole-operation result from closed-form shift/rotate arithmetic.
  function automatic void refModel(input logic [2:0] m, input int n, input logic [X-1:0] d,
                                   input logic [X-1:0] bits,
                                   output logic [X-1:0] rq, output logic rso);
    logic [2*X-1:0] t;
    rq  = d;
    rso = 1'b0;
    if (n == 0) return;
    case (m)
      3'd0: begin t = {{X{1'b0}}, d} >> n;   rq = t[X-1:0];   rso = d[n-1]; end
      3'd1: begin t = {{X{d[X-1]}}, d} >> n; rq = t[X-1:0];   rso = d[n-1]; end
      3'd2: begin t = {{X{1'b0}}, d} << n;   rq = t[X-1:0];   rso = d[X-n]; end
      3'd3: begin t = {d, d} >> n;           rq = t[X-1:0];   rso = d[n-1]; end
      3'd4: begin t = {d, d} << n;           rq = t[2*X-1:X]; rso = d[X-n]; end
      3'd5: begin
        t = {{X{1'b0}}, d} >> n;
        rq = t[X-1:0];
        for (int k = 0; k < n; k++) rq[X-n+k] = bits[k];
        rso = d[n-1];
      end
      3'd6: begin
        t = {{X{1'b0}}, d} << n;
        rq = t[X-1:0];
        for (int k = 0; k < n; k++) rq[n-1-k] = bits[k];
        rso = d[X-n];
      end
      default: begin rq = d; rso = 1'b0; end
    endcase
  endfunction

  // Issues one operation; bits[i] is the serial fill for shift step i.
  task automatic applyStimulus(input string name, input logic [2:0] m, input int a,
                               input logic [X-1:0] d, input logic [X-1:0] bits,
                               input bit noisy, input bit has_exp,
                               input logic [X-1:0] exp_q, input logic exp_so);
    int   n;
    exp_t e;
    logic [X-1:0] mq;
    logic mso;
    n = (a > X) ? X : a;
    refModel(m, n, d, bits, mq, mso);
    e.q        = has_exp ? exp_q : mq;
    e.so       = has_exp ? exp_so : mso;
    e.done_cyc = cyc + n + 1;
    e.name     = name;
    sb.push_back(e);
    last_q = e.q;
    start   = 1'b1;
    mode    = m;
    amount  = AW'(a);
    data_in = d;
    @(posedge clk); #1;
    for (int i = 1; i <= n + 1; i++) begin
      serial_in = (i <= n) ? bits[i-1] : 1'($urandom_range(0, 1));
      if (noisy) begin
        start   = 1'($urandom_range(0, 1));
        mode    = 3'($urandom_range(0, 7));
        amount  = AW'($urandom_range(0, 15));
        data_in = X'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic abortTest(input bit use_rst);
    start   = 1'b1;
    mode    = 3'd0;
    amount  = AW'(5);
    data_in = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    if (use_rst) rst = 1'b1;
    else         clr = 1'b1;
    @(posedge clk); #1;
    checkOutput(use_rst ? "rst_abort_q"    : "clr_abort_q",    q,         0);
    checkOutput(use_rst ? "rst_abort_so"   : "clr_abort_so",   shift_out, 0);
    checkOutput(use_rst ? "rst_abort_busy" : "clr_abort_busy", busy,      0);
    checkOutput(use_rst ? "rst_abort_done" : "clr_abort_done", done,      0);
    rst = 1'b0;
    clr = 1'b0;
    applyStimulus(use_rst ? "after_rst" : "after_clr", 3'd2, 2, 8'h81, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", done, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput({e.name, "_q"},    q,         e.q);
        checkOutput({e.name, "_so"},   shift_out, e.so);
        checkOutput({e.name, "_cyc"},  cyc,       e.done_cyc);
        checkOutput({e.name, "_busy"}, busy,      1);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    clr       = 1'b0;
    start     = 1'b0;
    mode      = '0;
    amount    = '0;
    data_in   = '0;
    serial_in = 1'b0;
    last_q    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_q",    q,         0);
    checkOutput("reset_so",   shift_out, 0);
    checkOutput("reset_busy", busy,      0);
    checkOutput("reset_done", done,      0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus("lsr_96_3",  3'd0, 3,  8'h96, 8'h00, 1'b0, 1'b1, 8'h12, 1'b1);
    applyStimulus("asr_a4_2",  3'd1, 2,  8'hA4, 8'h00, 1'b0, 1'b1, 8'hE9, 1'b0);
    applyStimulus("rol_81_1",  3'd4, 1,  8'h81, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1);
    applyStimulus("ror_5a_8",  3'd3, 8,  8'h5A, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0);
    applyStimulus("lsl_ff_12", 3'd2, 12, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1);
    applyStimulus("sli_00_3",  3'd6, 3,  8'h00, 8'hFF, 1'b0, 1'b1, 8'h07, 1'b0);
    applyStimulus("amt0_3c",   3'd0, 0,  8'h3C, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0);
    applyStimulus("ror_noisy", 3'd3, 8,  8'h5A, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0);
    applyStimulus("rsv_a5_4",  3'd7, 4,  8'hA5, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0);
    checkOutput("idle_after_rsv", q, 8'hA5);

    abortTest(1'b1);
    abortTest(1'b0);

    for (int i = 0; i < 150; i++) begin
      int gap;
      applyStimulus("rand", 3'($urandom_range(0, 7)), $urandom_range(0, 15), X'($urandom),
                    X'($urandom), 1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        data_in = X'($urandom);
        mode    = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
      end
      checkOutput("idle_hold_q",    q,    last_q);
      checkOutput("idle_hold_busy", busy, 0);
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #1;
    checkOutput("sb_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

Interface
REQ-001 SHALL have parameter x, default 8: data width in bits, legal values 2..64.
REQ-002 SHALL have a derived constant aw = $clog2(x)+1, which is the width of the amount field.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port clr, input, 1 bit: synchronous soft clear.
REQ-006 SHALL have port start, input, 1 bit: request a load-and-shift operation.
REQ-007 SHALL have port mode, input, 3 bits: shift mode for the operation, latched at start.
REQ-008 SHALL have port amount, input, aw bits: number of bit positions to shift, latched at start.
REQ-009 SHALL have port data_in, input, x bits: parallel operand, latched at start.
REQ-010 SHALL have port serial_in, input, 1 bit: fill bit for the SRI and SLI modes, sampled on each shift step.
REQ-011 SHALL have port q, output, x bits, registered: shift result.
REQ-012 SHALL have port shift_out, output, 1 bit, registered: the bit that left the register on the most recent shift step.
REQ-013 SHALL have port busy, output, 1 bit: high while state is not IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse, high while state is DONE.

Function
REQ-015 SHALL implement an FSM with the states IDLE, SHIFT and DONE.
REQ-016 In IDLE with start=1, the block SHALL perform all of the following on that edge:
- load q<=data_in and shift_out<=0
- latch mode
- latch cnt<=min(amount, x)
- go to SHIFT if the clamped count is nonzero, otherwise go to DONE.
REQ-017 In SHIFT, each edge SHALL perform one 1-bit step on q, set shift_out, and decrement cnt; when cnt==1, the state SHALL go to DONE.
REQ-018 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-019 Latency: with start high in cycle 0 and clamped amount n, done SHALL be high in cycle n+1 and busy high in cycles 1..n+1.
REQ-020 Mode encodings, each defining one step:
- 000 LSR: {0,q[x-1:1]}, out q[0]
- 001 ASR: {q[x-1],q[x-1:1]}, out q[0]
- 010 LSL: {q[x-2:0],0}, out q[x-1]
- 011 ROR: {q[0],q[x-1:1]}, out q[0]
- 100 ROL: {q[x-2:0],q[x-1]}, out q[x-1]
- 101 SRI: {serial_in,q[x-1:1]}, out q[0]
- 110 SLI: {q[x-2:0],serial_in}, out q[x-1]
REQ-021 Mode 111 is reserved: the counter SHALL still run and done SHALL still pulse, while q and shift_out hold.
REQ-022 start while busy SHALL be ignored with no effect; a start in the DONE cycle is also ignored.
REQ-023 q and shift_out SHALL hold their values in IDLE until the next accepted start or clr.
REQ-024 amount values greater than x SHALL clamp to x; an ROR or ROL by x therefore returns the original data.
REQ-025 clr SHALL, on the next edge, zero q, shift_out and cnt and force IDLE without a done pulse.
REQ-026 Priority SHALL be rst > clr > start/shift.

Reset
REQ-027 On rst, the next edge SHALL set q=0, shift_out=0, cnt=0, latched mode=000, state=IDLE, busy=0 and done=0.
REQ-028 rst asserted mid-operation SHALL abort the operation with no done pulse, and the block SHALL accept a start on the first edge after rst is released.

Structure
REQ-029 Mode encodings and FSM state encodings SHALL live in the shared package shift_pkg.
REQ-030 The single-step next-value and out-bit function SHALL be a combinational sub-module shift_step, parameterised by x.

Verification
REQ-031 x=8, LSR, data_in=8'h96, amount=3 -> q=8'h12, shift_out=1, done in cycle 4.
REQ-032 ASR on 8'hA4 with amount=2 -> q=8'hE9, shift_out=0; ROL on 8'h81 with amount=1 -> q=8'h03, shift_out=1.
REQ-033 ROR on 8'h5A with amount=8 -> q=8'h5A, done in cycle 9; LSL on 8'hFF with amount=12 -> amount clamps to 8, q=8'h00, done in cycle 9.
REQ-034 SLI with serial_in=1, data_in=8'h00, amount=3 -> q=8'h07; amount=0 with data_in=8'h3C -> q=8'h3C, done in cycle 1.
REQ-035 A start pulsed during SHIFT -> ignored, with the result and timing unchanged.
REQ-036 rst or clr in the 2nd shift cycle -> q=0, busy=0, no done pulse; a new start on the next edge is accepted.
